// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: byte type, default message length and the
// PRGA/decrypt state encoding.
package rc4_pkg;

  typedef logic [7:0] byte_t;

  // Message length shared by the key-schedule stage, this stage and the top.
  localparam int MSG_LENGTH_DEF = 32;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RD_I  = 4'd1,
    ST_LAT_I = 4'd2,
    ST_RD_J  = 4'd3,
    ST_LAT_J = 4'd4,
    ST_WR_I  = 4'd5,
    ST_WR_J  = 4'd6,
    ST_RD_F  = 4'd7,
    ST_LAT_F = 4'd8,
    ST_WR_D  = 4'd9,
    ST_DONE  = 4'd10
  } prga_state_e;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Bundle of the start/finish handshake plus the S-memory, encrypted ROM and
// decrypted RAM ports of the PRGA stage. The master side is the PRGA engine,
// the slave side is the controller and the memories.
interface rc4_prga_decrypt_if #(
  parameter int MSG_ADDR_W = 5
) ();
  import rc4_pkg::*;

  logic                  start;
  logic                  finish;
  byte_t                 s_address;
  byte_t                 s_data;
  logic                  s_wren;
  byte_t                 s_q;
  logic [MSG_ADDR_W-1:0] rom_address;
  byte_t                 rom_q;
  logic [MSG_ADDR_W-1:0] dec_address;
  byte_t                 dec_data;
  logic                  dec_wren;

  modport master (
    input  start,
    output finish,
    output s_address,
    output s_data,
    output s_wren,
    input  s_q,
    output rom_address,
    input  rom_q,
    output dec_address,
    output dec_data,
    output dec_wren
  );

  modport slave (
    output start,
    input  finish,
    input  s_address,
    input  s_data,
    input  s_wren,
    output s_q,
    input  rom_address,
    output rom_q,
    input  dec_address,
    input  dec_data,
    input  dec_wren
  );

endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator and decryptor. Runs the PRGA loop over the
// encrypted ROM, swapping S-memory entries and writing each plaintext byte
// to the decrypted RAM. All memories are synchronous-read, so every read
// is split into an address cycle and a latch cycle; 9 cycles per byte.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LENGTH = MSG_LENGTH_DEF,
  parameter int MSG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  rc4_prga_decrypt_if.master    bus
);

  localparam logic [MSG_ADDR_W-1:0] K_LAST = MSG_ADDR_W'(MSG_LENGTH - 1);

  prga_state_e           state_q;

  // Datapath registers
  byte_t                 i_q;
  byte_t                 j_q;
  logic [MSG_ADDR_W-1:0] k_q;
  byte_t                 si_q;
  byte_t                 sj_q;

  // Registered outputs
  logic                  finish_q;
  byte_t                 s_address_q;
  byte_t                 s_data_q;
  logic                  s_wren_q;
  logic [MSG_ADDR_W-1:0] rom_address_q;
  logic [MSG_ADDR_W-1:0] dec_address_q;
  byte_t                 dec_data_q;
  logic                  dec_wren_q;

  // Next-value arithmetic; all 8-bit sums wrap silently mod 256
  byte_t                 i_inc_d;
  byte_t                 j_sum_d;
  byte_t                 f_idx_d;
  byte_t                 dec_byte_d;
  logic [MSG_ADDR_W-1:0] k_inc_d;

  // Combinational index/data arithmetic feeding the FSM
  always_comb begin
    i_inc_d    = i_q + 8'd1;
    j_sum_d    = j_q + bus.s_q;
    f_idx_d    = si_q + sj_q;
    dec_byte_d = bus.s_q ^ bus.rom_q;
    k_inc_d    = k_q + MSG_ADDR_W'(1);
  end

  // PRGA FSM with datapath registers and Moore outputs registered on entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      i_q           <= 8'd0;
      j_q           <= 8'd0;
      k_q           <= '0;
      si_q          <= 8'd0;
      sj_q          <= 8'd0;
      finish_q      <= 1'b0;
      s_address_q   <= 8'd0;
      s_data_q      <= 8'd0;
      s_wren_q      <= 1'b0;
      rom_address_q <= '0;
      dec_address_q <= '0;
      dec_data_q    <= 8'd0;
      dec_wren_q    <= 1'b0;
    end else begin
      // Write strobes are single-cycle unless a write state re-asserts them
      s_wren_q   <= 1'b0;
      dec_wren_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            // i, j, k clear on leaving IDLE; RD_I then sees i = 0 + 1
            i_q         <= 8'd1;
            j_q         <= 8'd0;
            k_q         <= '0;
            s_address_q <= 8'd1;
            state_q     <= ST_RD_I;
          end else begin
            state_q     <= ST_IDLE;
          end
        end
        ST_RD_I: begin
          state_q <= ST_LAT_I;
        end
        ST_LAT_I: begin
          si_q        <= bus.s_q;
          j_q         <= j_sum_d;
          s_address_q <= j_sum_d;
          state_q     <= ST_RD_J;
        end
        ST_RD_J: begin
          state_q <= ST_LAT_J;
        end
        ST_LAT_J: begin
          // S[i] <= old S[j]
          sj_q        <= bus.s_q;
          s_address_q <= i_q;
          s_data_q    <= bus.s_q;
          s_wren_q    <= 1'b1;
          state_q     <= ST_WR_I;
        end
        ST_WR_I: begin
          // S[j] <= old S[i]; when i == j both writes store the same byte
          s_address_q <= j_q;
          s_data_q    <= si_q;
          s_wren_q    <= 1'b1;
          state_q     <= ST_WR_J;
        end
        ST_WR_J: begin
          // After the swap S[i]+S[j] equals old S[j]+old S[i]
          s_address_q   <= f_idx_d;
          rom_address_q <= k_q;
          state_q       <= ST_RD_F;
        end
        ST_RD_F: begin
          state_q <= ST_LAT_F;
        end
        ST_LAT_F: begin
          dec_address_q <= k_q;
          dec_data_q    <= dec_byte_d;
          dec_wren_q    <= 1'b1;
          state_q       <= ST_WR_D;
        end
        ST_WR_D: begin
          if (k_q == K_LAST) begin
            finish_q <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            k_q         <= k_inc_d;
            i_q         <= i_inc_d;
            s_address_q <= i_inc_d;
            state_q     <= ST_RD_I;
          end
        end
        ST_DONE: begin
          // A start still held high must not restart the block
          if (!bus.start) begin
            finish_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            finish_q <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        default: begin
          finish_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.finish      = finish_q;
  assign bus.s_address   = s_address_q;
  assign bus.s_data      = s_data_q;
  assign bus.s_wren      = s_wren_q;
  assign bus.rom_address = rom_address_q;
  assign bus.dec_address = dec_address_q;
  assign bus.dec_data    = dec_data_q;
  assign bus.dec_wren    = dec_wren_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Scoreboard bench for rc4_prga_decrypt: memory models, expected-write
// queues filled at stimulus time, and a negedge monitor that pops them.
module tb_rc4_prga_decrypt;
  import rc4_pkg::*;

  localparam int L = 32;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic ld_go;

  always #5 clk = ~clk;

  rc4_prga_decrypt_if #(.MSG_ADDR_W(5)) bus ();

  rc4_prga_decrypt #(.MSG_LENGTH(L), .MSG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  byte_t s_mem   [256];
  byte_t ld_img  [256];
  byte_t rom_mem [L];
  byte_t dec_mem [L];

  // Synchronous-read memories; ld_go copies a fresh S image and clears dec RAM
  always @(posedge clk) begin
    if (ld_go) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= ld_img[x];
      for (int x = 0; x < L; x++) dec_mem[x] <= 8'h00;
    end else begin
      if (bus.s_wren) s_mem[bus.s_address] <= bus.s_data;
      if (bus.dec_wren) dec_mem[bus.dec_address] <= bus.dec_data;
    end
    bus.s_q   <= s_mem[bus.s_address];
    bus.rom_q <= rom_mem[bus.rom_address];
  end

  wr_t q_s[$];
  wr_t q_d[$];
  int checks   = 0;
  int errors   = 0;
  int s_pulses = 0;
  int d_pulses = 0;

  // Monitor: every write strobe is compared against the scoreboard queues
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.s_wren === 1'b1) begin
        s_pulses++;
        checks++;
        if (q_s.size() == 0) begin
          errors++;
          $display("FAIL s_write unexpected actual=%02h:%02h required=none", bus.s_address, bus.s_data);
        end else begin
          e = q_s.pop_front();
          if (bus.s_address !== e.addr || bus.s_data !== e.data) begin
            errors++;
            $display("FAIL s_write actual=%02h:%02h required=%02h:%02h", bus.s_address, bus.s_data, e.addr, e.data);
          end
        end
      end
      if (bus.dec_wren === 1'b1) begin
        d_pulses++;
        checks++;
        if (q_d.size() == 0) begin
          errors++;
          $display("FAIL dec_write unexpected actual=%02h:%02h required=none", bus.dec_address, bus.dec_data);
        end else begin
          e = q_d.pop_front();
          if ({3'b000, bus.dec_address} !== e.addr || bus.dec_data !== e.data) begin
            errors++;
            $display("FAIL dec_write actual=%02h:%02h required=%02h:%02h", bus.dec_address, bus.dec_data, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Reference RC4 PRGA over the loaded image; fills expected write lists
  byte_t ms  [256];
  byte_t ks  [L];
  wr_t   m_s [2*L];
  wr_t   m_d [L];

  task automatic run_model();
    byte_t i, j, si, sj, fi;
    for (int x = 0; x < 256; x++) ms[x] = ld_img[x];
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < L; k++) begin
      i  = i + 8'd1;
      si = ms[i];
      j  = j + si;
      sj = ms[j];
      ms[i] = sj;
      ms[j] = si;
      m_s[2*k]   = {i, sj};
      m_s[2*k+1] = {j, si};
      fi    = si + sj;
      ks[k] = ms[fi];
      m_d[k] = {8'(k), ks[k] ^ rom_mem[k]};
    end
  endtask

  task automatic push_exp(input int n_s, input int n_d);
    for (int x = 0; x < n_s; x++) q_s.push_back(m_s[x]);
    for (int x = 0; x < n_d; x++) q_d.push_back(m_d[x]);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load_mem();
    @(negedge clk);
    ld_go = 1'b1;
    @(negedge clk);
    ld_go = 1'b0;
  endtask

  task automatic set_identity();
    for (int x = 0; x < 256; x++) ld_img[x] = 8'(x);
  endtask

  // Hand-derived expectations for identity S, enc = {41, 00, ...}
  task automatic hand_identity();
    m_s[0] = {8'h01, 8'h01};
    m_s[1] = {8'h01, 8'h01};
    m_s[2] = {8'h02, 8'h03};
    m_s[3] = {8'h03, 8'h02};
    m_d[0] = {8'h00, 8'h43};
    m_d[1] = {8'h01, 8'h05};
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_finish"}, 32'(bus.finish), 0);
    chk({tag, "_s_wren"}, 32'(bus.s_wren), 0);
    chk({tag, "_dec_wren"}, 32'(bus.dec_wren), 0);
    chk({tag, "_s_addr"}, 32'(bus.s_address), 0);
    chk({tag, "_s_data"}, 32'(bus.s_data), 0);
    chk({tag, "_rom_addr"}, 32'(bus.rom_address), 0);
    chk({tag, "_dec_addr"}, 32'(bus.dec_address), 0);
    chk({tag, "_dec_data"}, 32'(bus.dec_data), 0);
  endtask

  // Raise start; edge 0 samples it, then RD_I must address S[1]
  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("rd_i_addr", 32'(bus.s_address), 1);
  endtask

  // Wait for finish, bounded; reports the cycle number it rose in
  task automatic wait_finish(output int cyc);
    int edges;
    edges = 0;
    while (bus.finish !== 1'b1 && edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
    end
    cyc = edges + 1;
    if (bus.finish !== 1'b1) begin
      errors++;
      checks++;
      $display("FAIL finish_timeout actual=0 required=1");
    end
  endtask

  task automatic drop_start();
    bus.start = 1'b0;
    chk("finish_held", 32'(bus.finish), 1);
    @(posedge clk);
    #1;
    chk("finish_fall", 32'(bus.finish), 0);
  endtask

  task automatic full_run(input string tag);
    int cyc, s0, d0;
    s0 = s_pulses;
    d0 = d_pulses;
    do_start();
    wait_finish(cyc);
    chk({tag, "_finish_cycle"}, cyc, 9*L+1);
    chk({tag, "_s_pulses"}, s_pulses - s0, 2*L);
    chk({tag, "_dec_pulses"}, d_pulses - d0, L);
    chk({tag, "_sq_left"}, q_s.size(), 0);
    chk({tag, "_dq_left"}, q_d.size(), 0);
  endtask

  initial begin : stimulus
    int s0, d0;
    byte_t key [3];
    byte_t t, jj;
    string pt;

    reset     = 1'b1;
    bus.start = 1'b0;
    ld_go     = 1'b0;
    for (int x = 0; x < L; x++) rom_mem[x] = 8'(x * 7 + 3);
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;

    // Identity S, enc starts {41, 00}
    set_identity();
    rom_mem[0] = 8'h41;
    rom_mem[1] = 8'h00;
    load_mem();
    run_model();
    hand_identity();
    push_exp(2*L, L);
    full_run("ident");

    // start held high in DONE: no second run
    d0 = d_pulses;
    s0 = s_pulses;
    repeat (50) @(posedge clk);
    #1;
    chk("hold_dec_pulses", d_pulses - d0, 0);
    chk("hold_s_pulses", s_pulses - s0, 0);
    drop_start();

    // Restart from a fresh identity image: counters must start from zero
    load_mem();
    run_model();
    hand_identity();
    push_exp(2*L, L);
    full_run("restart");
    drop_start();

    // j and f-index wrap
    set_identity();
    ld_img[1]    = 8'hFF;
    ld_img[8'hFF] = 8'h10;
    rom_mem[0]   = 8'h00;
    load_mem();
    run_model();
    m_s[0] = {8'h01, 8'h10};
    m_s[1] = {8'hFF, 8'hFF};
    m_d[0] = {8'h00, 8'h0F};
    push_exp(2*L, L);
    full_run("wrap");
    drop_start();

    // Reset during WR_I of byte 5 (cycle 50)
    set_identity();
    rom_mem[0] = 8'h41;
    load_mem();
    run_model();
    push_exp(11, 5);
    s0 = s_pulses;
    d0 = d_pulses;
    do_start();
    repeat (49) @(posedge clk);
    #1;
    chk("wr_i_b5_wren", 32'(bus.s_wren), 1);
    chk("wr_i_b5_addr", 32'(bus.s_address), 6);
    reset     = 1'b1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs_zero("midrst");
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_s_pulses", s_pulses - s0, 11);
    chk("midrst_dec_pulses", d_pulses - d0, 5);
    chk("midrst_sq_left", q_s.size(), 0);
    chk("midrst_dq_left", q_d.size(), 0);
    chk("midrst_finish", 32'(bus.finish), 0);

    // Full message: KSA for key 00 02 49, ROM built from a known plaintext
    key[0] = 8'h00;
    key[1] = 8'h02;
    key[2] = 8'h49;
    set_identity();
    jj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      jj = jj + ld_img[x] + key[x % 3];
      t = ld_img[x];
      ld_img[x] = ld_img[jj];
      ld_img[jj] = t;
    end
    pt = "RC4 keystream decrypt test msg!!";
    for (int x = 0; x < L; x++) rom_mem[x] = 8'h00;
    run_model();
    for (int x = 0; x < L; x++) rom_mem[x] = byte_t'(pt[x]) ^ ks[x];
    load_mem();
    run_model();
    push_exp(2*L, L);
    full_run("full");
    for (int x = 0; x < L; x++) chk($sformatf("plain_%0d", x), 32'(dec_mem[x]), 32'(byte_t'(pt[x])));
    drop_start();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_prga_decrypt.md
# rc4_prga_decrypt

RC4 keystream generator and decryptor; the stage directly downstream of key scheduling. After the scheduler finishes permuting S-memory, this block runs the PRGA loop over the encrypted message ROM and writes each plaintext byte to the decrypted-message RAM. It signals completion with the lab's level start/finish handshake. It owns the S-memory port while active.

## Interface
Parameters:
- MSG_LENGTH, 32: number of message bytes processed.
- MSG_ADDR_W, 5: width of ROM/RAM message addresses; 2^MSG_ADDR_W >= MSG_LENGTH.

Ports:
- clk  in  1  sole clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  level request; sampled only in IDLE and DONE.
- finish  out  1  high only in DONE.
- s_address  out  8  S-memory address.
- s_data  out  8  S-memory write data.
- s_wren  out  1  S-memory write enable.
- s_q  in  8  S-memory read data.
- rom_address  out  MSG_ADDR_W  encrypted-message ROM address.
- rom_q  in  8  encrypted byte.
- dec_address  out  MSG_ADDR_W  decrypted RAM address.
- dec_data  out  8  plaintext byte.
- dec_wren  out  1  decrypted RAM write enable.

## Operation
- Algorithm per byte k = 0..MSG_LENGTH-1:
  - i = i+1
  - j = j+S[i]
  - swap S[i], S[j]
  - f = S[S[i]+S[j]]
  - dec[k] = f XOR enc[k]
- i, j and the f index are 8-bit, mod 256; wrap is silent.
- i, j and k are cleared to 0 on leaving IDLE.
- Registers:
  - i, j, k
  - si (old S[i])
  - sj (old S[j])
- FSM states and outputs:
  - IDLE: if start, go to RD_I.
  - RD_I: s_address = i+1; i updates.
  - LAT_I: latch si = s_q; compute j = j+s_q.
  - RD_J: s_address = j.
  - LAT_J: latch sj = s_q.
  - WR_I: s_address = i, s_data = sj, s_wren = 1.
  - WR_J: s_address = j, s_data = si, s_wren = 1.
  - RD_F: s_address = si+sj; rom_address = k.
  - LAT_F: wait state; s_q and rom_q become valid.
  - WR_D: dec_address = k, dec_data = s_q ^ rom_q, dec_wren = 1.
    - If k == MSG_LENGTH-1, go to DONE.
    - Otherwise k = k+1 and go to RD_I.
  - DONE: finish = 1.
    - Stay while start is high.
    - Go to IDLE when start is low.
- Outputs are Moore-decoded from state and registers. Write enables are high in exactly one cycle per write.
- When i == j, the two writes store the same value, so S is unchanged. No special case is needed.
- start falling mid-run is ignored.
- A start still held high in DONE does not restart the block.

## Timing
- Memories are synchronous-read. An address driven in cycle n gives q valid in cycle n+1.
- Each byte takes 9 cycles (RD_I..WR_D).
- Start latency:
  - start is sampled high in IDLE at edge 0.
  - RD_I runs in cycle 1.
  - finish rises at cycle 9*MSG_LENGTH+1 and holds until start is seen low.
  - finish then falls one cycle later, when the FSM returns to IDLE.
- Reset values:
  - state = IDLE
  - i = j = k = si = sj = 0
  - finish, s_wren, dec_wren = 0
  - all addresses and data = 0
- Reset mid-operation returns to IDLE on the next edge. Memory contents are not restored.

## Structure
- Shared package rc4_pkg holds:
  - the state enum typedef
  - byte_t (logic [7:0])
  - the default MSG_LENGTH constant, also used by the key-schedule stage and the top level
- No sub-module is needed. This is one FSM with a datapath of 5 registers. The top-level mux for S-memory ownership lives outside this block.

## Test plan
- **Identity S, MSG_LENGTH=2.** Set S[x]=x, enc = {0x41, 0x00}, pulse start.
  - Required: dec[0]=0x43, dec[1]=0x05.
  - Required: S[2]=3 and S[3]=2 afterwards.
  - Required: finish rises at cycle 19.
- **j and f-index wrap.** Identity S except S[1]=0xFF and S[0xFF]=0x10; MSG_LENGTH=1; enc[0]=0x00.
  - Required: j=0xFF.
  - Required: S[1]=0x10 and S[0xFF]=0xFF afterwards.
  - Required: dec[0]=S[0x0F]=0x0F.
- **i==j swap.** Identity S, first byte (i=j=1).
  - Required: two S writes, both of value 0x01 to address 1; S is unchanged.
- **Handshake.**
  - Hold start high after finish: no second run; dec_wren stays 0 for 50 cycles.
  - Drop start: finish goes low 1 cycle later.
  - Raise start again: a new run begins with i=j=k=0.
- **Reset mid-run.** Assert reset during WR_I of byte 5.
  - Required: next cycle all outputs are 0 and state is IDLE.
  - Required: no further writes until the next start.
- **Full message.** Use the reference KSA output for key 0x000249 and the course ROM.
  - Required: dec RAM equals the known plaintext.
  - Required: exactly MSG_LENGTH dec_wren pulses and 2*MSG_LENGTH s_wren pulses.
